// File: rtl/i2c_reg_sequencer_if.sv
// i2c_reg_sequencer_if
//   Groups the request/response handshake of the register sequencer and the
//   per-byte command bus it drives into the underlying i2c_master.
//
//   Request side : req_valid/req_ready, req_rw, req_dev_addr, req_reg_addr,
//                  req_wdata -> rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy
//   Command side : i2c_en, i2c_trig, i2c_start, i2c_stop, i2c_ack, tx_data
//                  <- tx_ready, tx_done, i2c_nack, rx_data, rx_done
//
//   modport master : the sequencer itself (drives commands and responses)
//   modport slave  : its environment (requester plus the i2c_master core)
interface i2c_reg_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_timeout;
  logic       busy;
  logic       i2c_en;
  logic       i2c_trig;
  logic       i2c_start;
  logic       i2c_stop;
  logic       i2c_ack;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       i2c_nack;
  logic [7:0] rx_data;
  logic       rx_done;

  modport master (
    input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
    input  tx_ready, tx_done, i2c_nack, rx_data, rx_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy,
    output i2c_en, i2c_trig, i2c_start, i2c_stop, i2c_ack, tx_data
  );

  modport slave (
    output req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
    output tx_ready, tx_done, i2c_nack, rx_data, rx_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy,
    input  i2c_en, i2c_trig, i2c_start, i2c_stop, i2c_ack, tx_data
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Turns one register-level request (single-byte write or read at a
//   device/register address) into the START/address/data/STOP command list
//   for i2c_master, collects ACK status and read data, and returns a
//   one-cycle response. A per-command watchdog aborts a hung bus.
//
//   Parameters : TIMEOUT_CYCLES - max cycles a single master command may take
//   Ports      : clk   - system clock
//                reset - synchronous, active-high
//                bus   - i2c_reg_sequencer_if.master (request/response and
//                        master command bus)
module i2c_reg_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                 clk,
  input logic                 reset,
  i2c_reg_sequencer_if.master bus
);

  localparam int WdW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  // Command codes as {stop,start}
  localparam logic [1:0] CmdWrite = 2'b00;
  localparam logic [1:0] CmdStart = 2'b01;
  localparam logic [1:0] CmdStop  = 2'b10;
  localparam logic [1:0] CmdRead  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SETUP, TRIG, WAIT_XFER, WAIT_READY, RESP, RECOVER
  } state_t;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] data;
    logic       ack;
  } cmd_t;

  state_t         state_q,   state_d;
  logic [2:0]     step_q,    step_d;
  logic           rw_q,      rw_d;
  logic [6:0]     devAddr_q, devAddr_d;
  logic [7:0]     regAddr_q, regAddr_d;
  logic [7:0]     wdata_q,   wdata_d;
  logic           nack_q,    nack_d;
  logic [7:0]     rdata_q,   rdata_d;
  logic           timeout_q, timeout_d;
  logic [WdW-1:0] wdog_q,    wdog_d;
  logic           recCnt_q,  recCnt_d;
  logic           afterTrig_q;
  logic           enable_q;
  cmd_t           cmd_q,     cmd_d;
  logic [2:0]     lastStep;
  logic [2:0]     nextStep;

  // Step list. Write: START, {dev,0}, reg, wdata, STOP.
  // Read: START, {dev,0}, reg, START, {dev,1}, READ(nack), STOP.
  function automatic cmd_t decodeStep(input logic rw, input logic [6:0] dev,
                                      input logic [7:0] regAddr,
                                      input logic [7:0] wdata,
                                      input logic [2:0] step);
    cmd_t c;
    c.code = CmdStop;
    c.data = 8'h00;
    c.ack  = 1'b0;
    case (step)
      3'd0: c.code = CmdStart;
      3'd1: begin c.code = CmdWrite; c.data = {dev, 1'b0}; end
      3'd2: begin c.code = CmdWrite; c.data = regAddr; end
      3'd3: begin
        if (rw) c.code = CmdStart;
        else begin c.code = CmdWrite; c.data = wdata; end
      end
      3'd4: if (rw) begin c.code = CmdWrite; c.data = {dev, 1'b1}; end
      3'd5: begin c.code = CmdRead; c.ack = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  assign lastStep = rw_q ? 3'd6 : 3'd4;
  // After a NACK the remaining bytes are skipped but the bus is still released
  assign nextStep = nack_q ? lastStep : step_q + 3'd1;

  // Next-state logic. The command registers are only reloaded on SETUP
  // entry, so the master never sees them change while it is busy.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rw_d      = rw_q;
    devAddr_d = devAddr_q;
    regAddr_d = regAddr_q;
    wdata_d   = wdata_q;
    nack_d    = nack_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    wdog_d    = wdog_q;
    recCnt_d  = 1'b0;
    cmd_d     = cmd_q;
    case (state_q)
      IDLE: begin
        if (enable_q && bus.req_valid) begin
          rw_d      = bus.req_rw;
          devAddr_d = bus.req_dev_addr;
          regAddr_d = bus.req_reg_addr;
          wdata_d   = bus.req_wdata;
          nack_d    = 1'b0;
          rdata_d   = 8'h00;
          timeout_d = 1'b0;
          step_d    = 3'd0;
          wdog_d    = '0;
          cmd_d     = decodeStep(bus.req_rw, bus.req_dev_addr,
                                 bus.req_reg_addr, bus.req_wdata, 3'd0);
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (wdog_q == WdLast) state_d = RECOVER;
        else begin
          wdog_d = wdog_q + WdW'(1);
          if (bus.tx_ready) state_d = TRIG;
        end
      end
      TRIG: begin
        // WRITE and READ have equal code bits; START/STOP do not
        if (cmd_q.code[1] == cmd_q.code[0]) state_d = WAIT_XFER;
        else                                state_d = WAIT_READY;
      end
      WAIT_XFER: begin
        if (wdog_q == WdLast) state_d = RECOVER;
        else begin
          wdog_d = wdog_q + WdW'(1);
          if (cmd_q.code == CmdWrite && bus.tx_done) begin
            nack_d  = nack_q | bus.i2c_nack;
            state_d = WAIT_READY;
          end else if (cmd_q.code == CmdRead && bus.rx_done) begin
            rdata_d = bus.rx_data;
            state_d = WAIT_READY;
          end
        end
      end
      WAIT_READY: begin
        if (wdog_q == WdLast) state_d = RECOVER;
        else begin
          wdog_d = wdog_q + WdW'(1);
          // tx_ready may still be stale in the cycle right after the strobe
          if (bus.tx_ready && !afterTrig_q) begin
            if (step_q == lastStep) state_d = RESP;
            else begin
              step_d  = nextStep;
              cmd_d   = decodeStep(rw_q, devAddr_q, regAddr_q, wdata_q, nextStep);
              wdog_d  = '0;
              state_d = SETUP;
            end
          end
        end
      end
      RESP: state_d = IDLE;
      RECOVER: begin
        recCnt_d = 1'b1;
        if (recCnt_q) begin
          timeout_d = 1'b1;
          rdata_d   = 8'h00;
          state_d   = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; enable_q holds outputs at their reset
  // values for the whole reset period and one cycle beyond
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= 3'd0;
      rw_q        <= 1'b0;
      devAddr_q   <= 7'h00;
      regAddr_q   <= 8'h00;
      wdata_q     <= 8'h00;
      nack_q      <= 1'b0;
      rdata_q     <= 8'h00;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
      recCnt_q    <= 1'b0;
      afterTrig_q <= 1'b0;
      enable_q    <= 1'b0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rw_q        <= rw_d;
      devAddr_q   <= devAddr_d;
      regAddr_q   <= regAddr_d;
      wdata_q     <= wdata_d;
      nack_q      <= nack_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      wdog_q      <= wdog_d;
      recCnt_q    <= recCnt_d;
      afterTrig_q <= (state_q == TRIG);
      enable_q    <= 1'b1;
      cmd_q       <= cmd_d;
    end
  end

  assign bus.req_ready   = enable_q && (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.i2c_en      = enable_q && (state_q != RECOVER);
  assign bus.i2c_trig    = (state_q == TRIG);
  assign bus.i2c_stop    = cmd_q.code[1];
  assign bus.i2c_start   = cmd_q.code[0];
  assign bus.tx_data     = cmd_q.data;
  assign bus.i2c_ack     = cmd_q.ack;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_nack    = (state_q == RESP) && nack_q;
  assign bus.rsp_timeout = (state_q == RESP) && timeout_q;
  // Read data is only reported on a clean completion
  assign bus.rsp_rdata   = ((state_q == RESP) && !nack_q && !timeout_q) ? rdata_q : 8'h00;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer
//   Directed bench for i2c_reg_sequencer with a small behavioural i2c_master
//   model. Expected command strobes and responses are queued when a request
//   is driven and compared when the DUT produces them.
module tb_i2c_reg_sequencer;

  localparam int TimeoutCycles = 50;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  i2c_reg_sequencer_if bus();

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] code;
    logic [7:0] data;
    logic       ack;
  } cmd_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       nack;
    logic       timeout;
  } rsp_t;

  cmd_t expTrig[$];
  rsp_t expRsp[$];
  int   checks   = 0;
  int   errors   = 0;
  int   rspCount = 0;
  logic hangArm  = 1'b0;
  logic nackEn   = 1'b0;
  logic [7:0] nackByte = 8'h00;
  logic [7:0] readByte = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  function automatic logic [31:0] outVec();
    return {6'b0, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_nack,
            bus.rsp_timeout, bus.busy, bus.i2c_en, bus.i2c_trig, bus.i2c_start,
            bus.i2c_stop, bus.i2c_ack, bus.tx_data};
  endfunction

  // Behavioural i2c_master: each command keeps tx_ready low for 3 cycles,
  // WRITE/READ pulse their done flag in the middle; a hang holds it low
  // until the sequencer drops i2c_en
  initial begin : masterModel
    int   mCnt;
    cmd_t cur, prevCmd, mCmd, exp;
    mCnt    = 0;
    prevCmd = '0;
    mCmd    = '0;
    bus.tx_ready = 1'b1;
    bus.tx_done  = 1'b0;
    bus.rx_done  = 1'b0;
    bus.i2c_nack = 1'b0;
    bus.rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      cur = cmd_t'({bus.i2c_stop, bus.i2c_start, bus.tx_data, bus.i2c_ack});
      bus.tx_done  = 1'b0;
      bus.rx_done  = 1'b0;
      bus.i2c_nack = 1'b0;
      if (reset || !bus.i2c_en) begin
        mCnt = 0;
        bus.tx_ready = 1'b1;
      end else if (bus.i2c_trig) begin
        checkOutput("trig_overlap", 32'(mCnt), 32'd0);
        checkOutput("cmd_setup_stable", 32'(prevCmd), 32'(cur));
        checkOutput("trig_expected", 32'(expTrig.size() != 0), 32'd1);
        if (expTrig.size() != 0) begin
          exp = expTrig.pop_front();
          checkOutput("trig_code", 32'(cur.code), 32'(exp.code));
          checkOutput("trig_data", 32'(cur.data), 32'(exp.data));
          checkOutput("trig_ack",  32'(cur.ack),  32'(exp.ack));
        end
        mCmd = cur;
        bus.tx_ready = 1'b0;
        mCnt = hangArm ? 1000000 : 3;
        hangArm = 1'b0;
      end else if (mCnt > 0) begin
        mCnt--;
        if (mCnt == 1) begin
          if (mCmd.code == 2'b00) begin
            bus.tx_done  = 1'b1;
            bus.i2c_nack = nackEn && (mCmd.data == nackByte);
          end else if (mCmd.code == 2'b11) begin
            bus.rx_done = 1'b1;
            bus.rx_data = readByte;
          end
        end
        if (mCnt == 0) bus.tx_ready = 1'b1;
      end
      prevCmd = cur;
    end
  end

  // Response scoreboard
  initial begin : rspMonitor
    rsp_t exp;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rspCount++;
        checkOutput("rsp_expected", 32'(expRsp.size() != 0), 32'd1);
        checkOutput("busy_with_rsp", 32'(bus.busy), 32'd1);
        if (expRsp.size() != 0) begin
          exp = expRsp.pop_front();
          checkOutput("rsp_rdata",   32'(bus.rsp_rdata),   32'(exp.rdata));
          checkOutput("rsp_nack",    32'(bus.rsp_nack),    32'(exp.nack));
          checkOutput("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp.timeout));
        end
      end
    end
  end

  // Queues the expected command list and response, then presents the request
  // until it is accepted
  task automatic applyStimulus(input logic rw, input logic [6:0] dev,
                               input logic [7:0] regA, input logic [7:0] wdata,
                               input bit expNack, input bit expTimeout,
                               input bit keepValid);
    int n;
    expTrig.push_back(cmd_t'({2'b01, 8'h00, 1'b0}));
    if (!expTimeout) begin
      expTrig.push_back(cmd_t'({2'b00, dev, 1'b0, 1'b0}));
      if (!expNack) begin
        expTrig.push_back(cmd_t'({2'b00, regA, 1'b0}));
        if (rw) begin
          expTrig.push_back(cmd_t'({2'b01, 8'h00, 1'b0}));
          expTrig.push_back(cmd_t'({2'b00, dev, 1'b1, 1'b0}));
          expTrig.push_back(cmd_t'({2'b11, 8'h00, 1'b1}));
        end else begin
          expTrig.push_back(cmd_t'({2'b00, wdata, 1'b0}));
        end
      end
      expTrig.push_back(cmd_t'({2'b10, 8'h00, 1'b0}));
    end
    expRsp.push_back(rsp_t'({(rw && !expNack && !expTimeout) ? readByte : 8'h00,
                             expNack, expTimeout}));
    bus.req_rw       = rw;
    bus.req_dev_addr = dev;
    bus.req_reg_addr = regA;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keepValid) bus.req_valid = 1'b0;
    checkOutput("busy_after_accept",  32'(bus.busy),      32'd1);
    checkOutput("ready_after_accept", 32'(bus.req_ready), 32'd0);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while ((expTrig.size() != 0 || expRsp.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(expTrig.size() + expRsp.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : globalGuard
    #1000000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin : stimulus
    int n;
    int low;
    int rspBefore;
    bit found;
    bus.req_valid    = 1'b0;
    bus.req_rw       = 1'b0;
    bus.req_dev_addr = 7'h00;
    bus.req_reg_addr = 8'h00;
    bus.req_wdata    = 8'h00;

    // Reset values and release
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", outVec(), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("en_after_reset",    32'(bus.i2c_en),    32'd1);
    checkOutput("ready_after_reset", 32'(bus.req_ready), 32'd1);

    // Plain write, all ACK
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, 1'b0, 1'b0);
    waitDone("write_done");

    // Read returning 0x3C
    readByte = 8'h3C;
    applyStimulus(1'b1, 7'h50, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    waitDone("read_done");

    // Address NACK: straight to STOP
    nackEn = 1'b1;
    nackByte = 8'hA0;
    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b1, 1'b0, 1'b0);
    waitDone("nack_done");
    nackEn = 1'b0;

    // Boundary data pattern
    applyStimulus(1'b0, 7'h7F, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    waitDone("write_edge_done");

    // Hung master after the first strobe
    hangArm = 1'b1;
    applyStimulus(1'b0, 7'h22, 8'h01, 8'h55, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!bus.i2c_trig && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.i2c_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", 32'(n), 32'd50);
    low = 0;
    while (!bus.i2c_en && low < 10) begin
      @(negedge clk);
      low++;
    end
    checkOutput("recover_en_low", 32'(low), 32'd2);
    waitDone("timeout_done");
    hangArm = 1'b0;

    applyStimulus(1'b0, 7'h22, 8'h01, 8'h55, 1'b0, 1'b0, 1'b0);
    waitDone("after_timeout_done");

    // Back-to-back with req_valid held
    readByte = 8'h5A;
    applyStimulus(1'b0, 7'h33, 8'h44, 8'h99, 1'b0, 1'b0, 1'b1);
    rspBefore = rspCount;
    applyStimulus(1'b1, 7'h34, 8'h45, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("b2b_second_after_rsp", 32'(rspCount), 32'(rspBefore + 1));
    waitDone("b2b_done");

    // Reset during WAIT_XFER of a read
    readByte = 8'h77;
    applyStimulus(1'b1, 7'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.i2c_trig && {bus.i2c_stop, bus.i2c_start} == 2'b00) found = 1'b1;
    end
    checkOutput("reset_trig_seen", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_outputs", outVec(), 32'd0);
    expTrig.delete();
    expRsp.delete();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("en_after_mid_reset",    32'(bus.i2c_en),    32'd1);
    checkOutput("ready_after_mid_reset", 32'(bus.req_ready), 32'd1);
    checkOutput("no_rsp_after_reset",    32'(bus.rsp_valid), 32'd0);

    applyStimulus(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, 1'b0, 1'b0);
    waitDone("post_reset_write_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
